// File: rtl/ttl_pkg.sv
// Shared constants for the 74-series behavioural models.
// The delay constants are only used by builds that define TTL_74163_TIMING_EN.
`timescale 1ns/10ps
package ttl_pkg;
  localparam int NIBBLE = 4;

  // 74LS163 datasheet delays in ns.
  localparam int T163_CQ_MIN  = 0;
  localparam int T163_CQ_TYP  = 18;
  localparam int T163_CQ_MAX  = 27;
  localparam int T163_RCO_MIN = 0;
  localparam int T163_RCO_TYP = 14;
  localparam int T163_RCO_MAX = 23;
endpackage

// File: rtl/ttl_74163_stage.sv
// One 74LS163 chip: sync clear, sync parallel load, count with ENP/ENT, and RCO.
// Define TTL_74163_TIMING_EN to get datasheet clock-to-Q and RCO delays.
`timescale 1ns/10ps
module ttl_74163_stage
  import ttl_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              LOAD_N,
  input  logic              ENP,
  input  logic              ENT,
  input  logic [NIBBLE-1:0] D,
  output logic [NIBBLE-1:0] Q,
  output logic              RCO
);
  logic [NIBBLE-1:0] r_q;
  logic [NIBBLE-1:0] w_q_nxt;
  logic              w_rco;

  // Ternaries rather than if/else so an X control merges the branches into X.
  always_comb begin
    w_q_nxt = !LOAD_N ? D : ((ENP & ENT) ? r_q + 1'b1 : r_q);
  end

  always_ff @(posedge CLK) begin
    r_q <= !CLR_N ? '0 : w_q_nxt;
  end

  // Decoded from the visible Q, so in the timed build RCO lags Q.
  assign w_rco = ENT & (&Q);

`ifdef TTL_74163_TIMING_EN
  assign #(T163_CQ_MIN:T163_CQ_TYP:T163_CQ_MAX)    Q   = r_q;
  assign #(T163_RCO_MIN:T163_RCO_TYP:T163_RCO_MAX) RCO = w_rco;
`else
  assign Q   = r_q;
  assign RCO = w_rco;
`endif
endmodule

// File: rtl/ttl_74163_counter.sv
// STAGES cascaded 74LS163 chips forming a 4*STAGES-bit synchronous counter.
// Each stage's ENT is the previous stage's RCO. Timing build: TTL_74163_TIMING_EN.
`timescale 1ns/10ps
module ttl_74163_counter
  import ttl_pkg::*;
#(
  parameter  int STAGES = 1,
  localparam int W      = NIBBLE * STAGES
) (
  input  logic         CLK,
  input  logic         CLR_N,
  input  logic         LOAD_N,
  input  logic         ENP,
  input  logic         ENT,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         RCO
);
  logic [STAGES:0] w_ent;

  assign w_ent[0] = ENT;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ttl_74163_stage u_stage (
      .CLK    (CLK),
      .CLR_N  (CLR_N),
      .LOAD_N (LOAD_N),
      .ENP    (ENP),
      .ENT    (w_ent[k]),
      .D      (D[k*NIBBLE +: NIBBLE]),
      .Q      (Q[k*NIBBLE +: NIBBLE]),
      .RCO    (w_ent[k+1])
    );
  end

  assign RCO = w_ent[STAGES];
endmodule

// File: tb/tb_ttl_74163_counter.sv
// Directed bench for ttl_74163_counter: a 1-stage and a 2-stage instance on shared controls.
// With TTL_74163_TIMING_EN defined, typical clock-to-Q and RCO delays are also checked.
`timescale 1ns/10ps
module tb_ttl_74163_counter;
  logic       CLK = 1'b0;
  logic       CLR_N, LOAD_N, ENP, ENT;
  logic [3:0] D1, Q1;
  logic [7:0] D2, Q2;
  logic       RCO1, RCO2;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #100 CLK = ~CLK;

  ttl_74163_counter #(.STAGES(1)) u1 (
    .CLK(CLK), .CLR_N(CLR_N), .LOAD_N(LOAD_N), .ENP(ENP), .ENT(ENT),
    .D(D1), .Q(Q1), .RCO(RCO1)
  );

  ttl_74163_counter #(.STAGES(2)) u2 (
    .CLK(CLK), .CLR_N(CLR_N), .LOAD_N(LOAD_N), .ENP(ENP), .ENT(ENT),
    .D(D2), .Q(Q2), .RCO(RCO2)
  );

  // Advance one rising edge and settle well past the worst-case output delays.
  task automatic step();
    @(posedge CLK);
    #80;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0; LOAD_N = 1'b0; ENP = 1'b1; ENT = 1'b1; D1 = 4'hA; D2 = 8'hAA;
    step();
    n_cmp++; if (Q1 !== 4'h0) begin n_bad++; $display("FAIL reset_q1 got %h want 0", Q1); end
    n_cmp++; if (RCO1 !== 1'b0) begin n_bad++; $display("FAIL reset_rco1 got %b want 0", RCO1); end
    n_cmp++; if (Q2 !== 8'h00) begin n_bad++; $display("FAIL reset_q2 got %h want 00", Q2); end
    n_cmp++; if (RCO2 !== 1'b0) begin n_bad++; $display("FAIL reset_rco2 got %b want 0", RCO2); end
  endtask

  task automatic test_load_count();
    logic [3:0] exp_q [3];
    logic       exp_r [3];
    exp_q = '{4'hE, 4'hF, 4'h0};
    exp_r = '{1'b0, 1'b1, 1'b0};
    CLR_N = 1'b1; LOAD_N = 1'b0; D1 = 4'hD;
    step();
    n_cmp++; if (Q1 !== 4'hD) begin n_bad++; $display("FAIL load_q got %h want d", Q1); end
    n_cmp++; if (RCO1 !== 1'b0) begin n_bad++; $display("FAIL load_rco got %b want 0", RCO1); end
    LOAD_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (Q1 !== exp_q[i]) begin n_bad++; $display("FAIL count_q[%0d] got %h want %h", i, Q1, exp_q[i]); end
      n_cmp++; if (RCO1 !== exp_r[i]) begin n_bad++; $display("FAIL count_rco[%0d] got %b want %b", i, RCO1, exp_r[i]); end
    end
  endtask

  task automatic test_enable_gating();
    LOAD_N = 1'b0; D1 = 4'hF;
    step();
    LOAD_N = 1'b1; ENP = 1'b0; ENT = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (Q1 !== 4'hF) begin n_bad++; $display("FAIL enp_hold_q[%0d] got %h want f", i, Q1); end
      n_cmp++; if (RCO1 !== 1'b1) begin n_bad++; $display("FAIL enp_hold_rco[%0d] got %b want 1", i, RCO1); end
    end
    ENT = 1'b0;
    #30;
    n_cmp++; if (RCO1 !== 1'b0) begin n_bad++; $display("FAIL ent_gate_rco got %b want 0", RCO1); end
    n_cmp++; if (Q1 !== 4'hF) begin n_bad++; $display("FAIL ent_gate_q got %h want f", Q1); end
    ENP = 1'b1;
    step();
    n_cmp++; if (Q1 !== 4'hF) begin n_bad++; $display("FAIL ent_hold_q got %h want f", Q1); end
    n_cmp++; if (RCO1 !== 1'b0) begin n_bad++; $display("FAIL ent_hold_rco got %b want 0", RCO1); end
    ENT = 1'b1;
  endtask

  task automatic test_cascade();
    logic [7:0] exp_q [3];
    exp_q = '{8'h0F, 8'h10, 8'h11};
    ENP = 1'b1; ENT = 1'b1; LOAD_N = 1'b0; D2 = 8'h0E;
    step();
    n_cmp++; if (Q2 !== 8'h0E) begin n_bad++; $display("FAIL casc_load got %h want 0e", Q2); end
    LOAD_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (Q2 !== exp_q[i]) begin n_bad++; $display("FAIL casc_q[%0d] got %h want %h", i, Q2, exp_q[i]); end
      n_cmp++; if (RCO2 !== 1'b0) begin n_bad++; $display("FAIL casc_rco[%0d] got %b want 0", i, RCO2); end
    end
    LOAD_N = 1'b0; D2 = 8'hFF;
    step();
    n_cmp++; if (Q2 !== 8'hFF) begin n_bad++; $display("FAIL casc_ff_q got %h want ff", Q2); end
    n_cmp++; if (RCO2 !== 1'b1) begin n_bad++; $display("FAIL casc_ff_rco got %b want 1", RCO2); end
    LOAD_N = 1'b1;
    step();
    n_cmp++; if (Q2 !== 8'h00) begin n_bad++; $display("FAIL casc_wrap_q got %h want 00", Q2); end
    n_cmp++; if (RCO2 !== 1'b0) begin n_bad++; $display("FAIL casc_wrap_rco got %b want 0", RCO2); end
  endtask

  task automatic test_clear_mid();
    LOAD_N = 1'b0; D2 = 8'h37;
    step();
    LOAD_N = 1'b1;
    // Clear pulse that is gone before the edge must be ignored.
    CLR_N = 1'b0; #10; CLR_N = 1'b1;
    step();
    n_cmp++; if (Q2 !== 8'h38) begin n_bad++; $display("FAIL clr_glitch got %h want 38", Q2); end
    CLR_N = 1'b0;
    step();
    n_cmp++; if (Q2 !== 8'h00) begin n_bad++; $display("FAIL clr_edge got %h want 00", Q2); end
    CLR_N = 1'b1;
    step();
    n_cmp++; if (Q2 !== 8'h01) begin n_bad++; $display("FAIL clr_resume got %h want 01", Q2); end
  endtask

  task automatic test_back_to_back();
    LOAD_N = 1'b0; D1 = 4'h5; D2 = 8'hA5;
    step();
    n_cmp++; if (Q1 !== 4'h5) begin n_bad++; $display("FAIL b2b_load1 got %h want 5", Q1); end
    n_cmp++; if (Q2 !== 8'hA5) begin n_bad++; $display("FAIL b2b_load2 got %h want a5", Q2); end
    D1 = 4'h9;
    step();
    n_cmp++; if (Q1 !== 4'h9) begin n_bad++; $display("FAIL b2b_reload got %h want 9", Q1); end
    LOAD_N = 1'b1;
    step();
    n_cmp++; if (Q1 !== 4'hA) begin n_bad++; $display("FAIL b2b_count got %h want a", Q1); end
  endtask

`ifdef TTL_74163_TIMING_EN
  task automatic test_timing();
    LOAD_N = 1'b0; D1 = 4'hE; ENP = 1'b1; ENT = 1'b1;
    step();
    LOAD_N = 1'b1;
    @(posedge CLK);
    #17;
    n_cmp++; if (Q1 !== 4'hE) begin n_bad++; $display("FAIL tcq_early got %h want e", Q1); end
    #2;
    n_cmp++; if (Q1 !== 4'hF) begin n_bad++; $display("FAIL tcq_late got %h want f", Q1); end
    #12;
    n_cmp++; if (RCO1 !== 1'b0) begin n_bad++; $display("FAIL trco_early got %b want 0", RCO1); end
    n_cmp++; if (Q1 !== 4'hF) begin n_bad++; $display("FAIL tq_stable got %h want f", Q1); end
    #2;
    n_cmp++; if (RCO1 !== 1'b1) begin n_bad++; $display("FAIL trco_late got %b want 1", RCO1); end
    #50;
  endtask
`endif

  initial begin
    test_reset();
    test_load_count();
    test_enable_gating();
    test_cascade();
    test_clear_mid();
    test_back_to_back();
`ifdef TTL_74163_TIMING_EN
    test_timing();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
